// File: rtl/vga_fetch_buffer.sv
// vga_fetch_buffer: holds the 32-bit row bitmap for the VGA stage's current word
// address and re-fetches from shared memory over a level req / 1-cycle ack
// handshake only when the address changes. A fetch that never gets an ack is
// abandoned after TIMEOUT cycles; the word then reads as zero and fetch_err sticks
// until clr.
// Optional build macro FETCH_PREFETCH_EN adds a one-word look-ahead entry. While the
// demand word hits, this entry fetches the next sequential word. A later miss on
// that word swaps it in without a memory access.
module vga_fetch_buffer #(
  parameter int ADR_W   = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              dclk,
  input  logic              clr,
  input  logic [ADR_W-1:0]  vadr,
  output logic [DATA_W-1:0] vdata,
  output logic              mem_req,
  output logic [ADR_W-1:0]  mem_adr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              fetch_err
);

  localparam int TAG_W = ADR_W - 2;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

`ifdef FETCH_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, REQ, PF_REQ} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ} state_t;
`endif

  state_t           state;
  logic [TAG_W-1:0] tag;
  logic             tag_valid;
  logic [CNT_W-1:0] wait_cnt;

  logic [TAG_W-1:0] vadr_tag;
  logic             miss;
  logic             expired;
  logic [CNT_W-1:0] wait_nxt;
  logic             unused_lsb;

  // Byte offset within the word never selects anything.
  assign unused_lsb = ^vadr[1:0];

  assign vadr_tag = vadr[ADR_W-1:2];
  assign miss     = !tag_valid || (vadr_tag != tag);
  assign expired  = (wait_cnt == CNT_W'(TIMEOUT - 1));
  // Saturate rather than wrap so a stuck counter can never alias back to zero.
  assign wait_nxt = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + CNT_W'(1);

`ifdef FETCH_PREFETCH_EN
  logic [DATA_W-1:0] pf_data;
  logic [TAG_W-1:0]  pf_tag;
  logic              pf_valid;
  logic [TAG_W-1:0]  tag_next;
  logic              pf_has_next;
  logic              pf_swap;

  // Next sequential word wraps naturally at the top of the address space.
  assign tag_next    = tag + TAG_W'(1);
  assign pf_has_next = pf_valid && (pf_tag == tag_next);
  assign pf_swap     = pf_valid && (pf_tag == vadr_tag);
`endif

  // Fetch controller: demand fills (and look-ahead fills), timeout, sticky error.
  always_ff @(posedge dclk) begin
    if (clr) begin
      state     <= IDLE;
      vdata     <= '0;
      mem_req   <= 1'b0;
      mem_adr   <= '0;
      fetch_err <= 1'b0;
      tag       <= '0;
      tag_valid <= 1'b0;
      wait_cnt  <= '0;
`ifdef FETCH_PREFETCH_EN
      pf_data   <= '0;
      pf_tag    <= '0;
      pf_valid  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef FETCH_PREFETCH_EN
          if (miss && pf_swap) begin
            // Look-ahead word already on hand: promote it, no memory traffic.
            vdata     <= pf_data;
            tag       <= pf_tag;
            tag_valid <= 1'b1;
            pf_valid  <= 1'b0;
          end else if (miss) begin
            mem_adr  <= vadr;
            mem_req  <= 1'b1;
            wait_cnt <= '0;
            state    <= REQ;
          end else if (!pf_has_next) begin
            mem_adr  <= {tag_next, 2'b00};
            mem_req  <= 1'b1;
            wait_cnt <= '0;
            state    <= PF_REQ;
          end
`else
          if (miss) begin
            mem_adr  <= vadr;
            mem_req  <= 1'b1;
            wait_cnt <= '0;
            state    <= REQ;
          end
`endif
        end
        REQ: begin
          // vadr is deliberately not looked at here; a change is seen back in IDLE.
          if (mem_ack) begin
            vdata     <= mem_rdata;
            tag       <= mem_adr[ADR_W-1:2];
            tag_valid <= 1'b1;
            mem_req   <= 1'b0;
            state     <= IDLE;
          end else if (expired) begin
            // Mark the dead address as filled so it is not retried every cycle.
            vdata     <= '0;
            tag       <= mem_adr[ADR_W-1:2];
            tag_valid <= 1'b1;
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
`ifdef FETCH_PREFETCH_EN
        PF_REQ: begin
          if (mem_ack) begin
            pf_data  <= mem_rdata;
            pf_tag   <= mem_adr[ADR_W-1:2];
            pf_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end else if (expired) begin
            pf_data   <= '0;
            pf_tag    <= mem_adr[ADR_W-1:2];
            pf_valid  <= 1'b1;
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
`endif
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fetch_buffer.sv
// Bench for vga_fetch_buffer (default build). Stimulus queues the expected
// mem_req edges (rise: address; fall: vdata/fetch_err) with the clock edge they
// must occur on; a negedge monitor pops and compares each edge it observes.
module tb_vga_fetch_buffer;

  localparam int ADR_W   = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 255;

  logic              dclk = 1'b0;
  logic              clr  = 1'b0;
  logic [ADR_W-1:0]  vadr = '0;
  logic [DATA_W-1:0] vdata;
  logic              mem_req;
  logic [ADR_W-1:0]  mem_adr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack   = 1'b0;
  logic              fetch_err;

  vga_fetch_buffer #(.ADR_W(ADR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .dclk(dclk), .clr(clr), .vadr(vadr), .vdata(vdata),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .fetch_err(fetch_err)
  );

  always #5 dclk = ~dclk;

  typedef struct {
    logic        rise;
    logic [31:0] val;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  logic prev_req = 1'b0;

  always @(posedge dclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected events land on the next rising edge (cyc+1).
  task automatic exp_req(input logic [31:0] adr);
    exp_q.push_back('{rise: 1'b1, val: adr, err: 1'b0, cyc: cyc + 1});
  endtask

  task automatic exp_end(input logic [31:0] data, input logic err);
    exp_q.push_back('{rise: 1'b0, val: data, err: err, cyc: cyc + 1});
  endtask

  task automatic step();
    @(posedge dclk);
    #1;
  endtask

  // Monitor: every mem_req edge must match the head of the expectation queue.
  always @(negedge dclk) begin
    exp_t e;
    if (mon_en && (mem_req !== prev_req)) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_req_edge: mem_req=%0b mem_adr=0x%08h, expected no edge (cycle %0d)",
                 mem_req, mem_adr, cyc);
      end else begin
        e = exp_q.pop_front();
        check("edge_dir", {31'd0, mem_req}, {31'd0, e.rise});
        check("edge_cycle", cyc, e.cyc);
        if (e.rise) begin
          check("mem_adr", mem_adr, e.val);
        end else begin
          check("vdata_at_end", vdata, e.val);
          check("fetch_err_at_end", {31'd0, fetch_err}, {31'd0, e.err});
        end
      end
    end
    prev_req = mem_req;
  end

  initial begin
    // 1: reset, then miss on 0xA0 filled three cycles after request
    vadr = 32'hA0;
    clr  = 1'b1;
    step();
    step();
    check("rst_vdata", vdata, 32'h0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_adr", mem_adr, 32'h0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    mon_en = 1'b1;
    clr = 1'b0;
    exp_req(32'hA0);
    step();
    step();
    step();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    exp_end(32'hDEADBEEF, 1'b0);
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    check("fill_a0", vdata, 32'hDEADBEEF);

    // 2: long hold on a hit, with a stray ack while idle
    repeat (500) step();
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    step();
    mem_ack = 1'b0;
    repeat (500) step();
    check("hold_vdata", vdata, 32'hDEADBEEF);
    check("hold_no_req", {31'd0, mem_req}, 32'd0);

    // 3: address changes mid-fetch; fetch completes, then re-request; ack in first REQ cycle
    vadr = 32'hB0;
    exp_req(32'hB0);
    step();
    vadr = 32'hB4;
    step();
    step();
    check("adr_held", mem_adr, 32'hB0);
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    exp_end(32'h11111111, 1'b0);
    step();
    mem_ack = 1'b0;
    exp_req(32'hB4);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h22222222;
    exp_end(32'h22222222, 1'b0);
    step();
    mem_ack = 1'b0;
    step();

    // ack on the last permitted cycle: ack wins, no error
    vadr = 32'hC0;
    exp_req(32'hC0);
    step();
    repeat (TIMEOUT - 1) step();
    mem_ack = 1'b1; mem_rdata = 32'h33333333;
    exp_end(32'h33333333, 1'b0);
    step();
    mem_ack = 1'b0;
    check("late_ack_err", {31'd0, fetch_err}, 32'd0);

    // 4: never acked -> abandon after TIMEOUT cycles, zero data, sticky error, no retry
    vadr = 32'hD0;
    exp_req(32'hD0);
    step();
    repeat (TIMEOUT - 1) step();
    exp_end(32'h0, 1'b1);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h44444444;
    step();
    mem_ack = 1'b0;
    repeat (20) step();
    check("to_vdata", vdata, 32'h0);
    check("to_err_sticky", {31'd0, fetch_err}, 32'd1);
    vadr = 32'hE0;
    exp_req(32'hE0);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    exp_end(32'h55555555, 1'b1);
    step();
    mem_ack = 1'b0;

    // 5: clr mid-fetch; ack arriving during reset is ignored; refetch after release
    vadr = 32'hF0;
    exp_req(32'hF0);
    step();
    step();
    clr = 1'b1;
    exp_end(32'h0, 1'b0);
    step();
    check("clr_err", {31'd0, fetch_err}, 32'd0);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h66666666;
    step();
    mem_ack = 1'b0;
    check("clr_ack_ignored", vdata, 32'h0);
    clr = 1'b0;
    exp_req(32'hF0);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    exp_end(32'h77777777, 1'b0);
    step();
    mem_ack = 1'b0;
    repeat (3) step();
    check("final_vdata", vdata, 32'h77777777);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
